// File: rtl/mips_defs.sv
// ---------------------------------------------------------------------------
// mips_defs
// Shared pipeline definitions for the write-back tag stream. The stream is
// the Res/A3 pair: Res says which unit produces the result, and A3 says which
// register receives it.
//   Res code width, register address width, Res code values, plus helpers
//   that classify a Res code as "writes a register" or "slow" (the result
//   cannot be forwarded to a D-stage reader).
// ---------------------------------------------------------------------------
package mips_defs;

    localparam int RES_W    = 3;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 1 << REG_AW;

    localparam logic [RES_W-1:0] RES_NW  = 3'd0;
    localparam logic [RES_W-1:0] RES_ALU = 3'd1;
    localparam logic [RES_W-1:0] RES_DM  = 3'd2;
    localparam logic [RES_W-1:0] RES_PC  = 3'd3;
    localparam logic [RES_W-1:0] RES_MD  = 3'd4;

    // Codes 5-7 are unused encodings and behave exactly like RES_NW.
    function automatic logic res_writes(input logic [RES_W-1:0] res);
        return (res == RES_ALU) || (res == RES_DM) || (res == RES_PC) || (res == RES_MD);
    endfunction

    // Load and mult/div results arrive too late to be forwarded to D.
    function automatic logic res_slow(input logic [RES_W-1:0] res);
        return (res == RES_DM) || (res == RES_MD);
    endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// ---------------------------------------------------------------------------
// md_busy_ctr
// Loadable down-counter that models the occupancy of the multi-cycle
// mult/div unit. A load starts a run of MULT_CYCLES or DIV_CYCLES cycles.
// After that the counter counts down to zero and holds there.
// Ports:
//   clk      pipeline clock
//   reset    asynchronous active-low reset
//   i_load   start a new mult/div operation this cycle
//   i_is_div 1 = divide (DIV_CYCLES), 0 = multiply (MULT_CYCLES)
//   o_busy   unit is running (counter non-zero)
// ---------------------------------------------------------------------------
module md_busy_ctr #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_is_div,
    output logic o_busy
);

    localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int MD_W   = $clog2(MD_MAX + 1);

    logic [MD_W-1:0] r_cnt;
    logic [MD_W-1:0] w_cnt_next;

    // NOTE: every variable assigned in always_comb gets a default first.
    // Without it, a path that skips the assignment infers a latch.
    always_comb begin
        w_cnt_next = r_cnt;
        if (i_load) begin
            w_cnt_next = i_is_div ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES);
        end else if (r_cnt != '0) begin
            w_cnt_next = r_cnt - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments, so every flop
    // samples the values from before the clock edge. Blocking assignments
    // here would create ordering races between processes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/wb_scoreboard.sv
// ---------------------------------------------------------------------------
// wb_scoreboard
// Tracks register writes that are in flight, from issue (D->E) until they
// retire in W. When a D-stage source has a pending writer that cannot be
// forwarded, the block raises a conservative interlock. It also stalls
// HI/LO users while the mult/div unit is busy.
// Ports:
//   clk, reset             clock, asynchronous active-low reset
//   issue_valid            D instruction advances into E this cycle
//   issue_res, issue_a3    Res code / destination of the issuing instruction
//   rs_addr, rt_addr       D-stage source registers
//   rs_used, rt_used       D instruction actually reads rs / rt
//   md_start, md_is_div    issuing instruction is mult/div, and which one
//   md_use                 D instruction touches HI/LO or the md unit
//   Res_W, A3_W            Res code / destination retiring in W
//   stall                  freeze PC and D, bubble E
//   md_busy                mult/div unit running
//   ovf_err                sticky pending-counter overflow/underflow flag
// ---------------------------------------------------------------------------
module wb_scoreboard
    import mips_defs::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic [RES_W-1:0]  issue_res,
    input  logic [REG_AW-1:0] issue_a3,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic              rs_used,
    input  logic              rt_used,
    input  logic              md_start,
    input  logic              md_is_div,
    input  logic              md_use,
    input  logic [RES_W-1:0]  Res_W,
    input  logic [REG_AW-1:0] A3_W,
    output logic              stall,
    output logic              md_busy,
    output logic              ovf_err
);

    logic [NUM_REGS-1:0] w_pending;   // register has a pending slow writer
    logic [NUM_REGS-1:0] w_ovf;       // per-register overflow/underflow event
    logic                w_issue_fire;
    logic                w_issue_slow;
    logic                w_retire;
    logic                w_md_load;
    logic                r_ovf_err;

    // A stalled instruction does not really issue, even when issue_valid is
    // high. Because stall depends only on state and D inputs, there is no
    // combinational loop through this term.
    assign w_issue_fire = issue_valid & res_writes(issue_res) & ~stall;
    assign w_issue_slow = res_slow(issue_res);
    assign w_retire     = res_writes(Res_W);

    // r0 is never pending. A zero bit here also removes any need for
    // explicit rs/rt != 0 checks in the stall equation.
    assign w_pending[0] = 1'b0;
    assign w_ovf[0]     = 1'b0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
        logic [CNT_W-1:0] r_cnt;
        logic             r_slow;
        logic             w_inc;
        logic             w_dec;

        assign w_inc = w_issue_fire & (issue_a3 == REG_AW'(g));
        assign w_dec = w_retire     & (A3_W     == REG_AW'(g));

        // NOTE: the counters are individually reset flops, not a RAM.
        // stall reads all of them combinationally, so each must be valid
        // straight out of reset.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_cnt  <= '0;
                r_slow <= 1'b0;
            end else begin
                // Saturate on overflow and clamp on underflow. ovf_err
                // records that either one happened.
                if (w_inc && !w_dec && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + 1'b1;
                end else if (w_dec && !w_inc && (r_cnt != '0)) begin
                    r_cnt <= r_cnt - 1'b1;
                end

                // The newest writer decides the type. A retire that empties
                // the register clears it.
                if (w_inc) begin
                    r_slow <= w_issue_slow;
                end else if (w_dec && (r_cnt <= CNT_W'(1))) begin
                    r_slow <= 1'b0;
                end
            end
        end

        assign w_ovf[g]     = (w_inc & ~w_dec & (r_cnt == '1)) |
                              (w_dec & ~w_inc & (r_cnt == '0));
        assign w_pending[g] = (r_cnt != '0) & r_slow;
    end

    assign stall = (rs_used & w_pending[rs_addr]) |
                   (rt_used & w_pending[rt_addr]) |
                   (md_use  & md_busy);

    // No md_start can arrive while the unit is busy: the issuing
    // instruction is itself an md_use, so it stalls.
    assign w_md_load = issue_valid & md_start & ~stall;

    md_busy_ctr #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_ctr (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_md_load),
        .i_is_div (md_is_div),
        .o_busy   (md_busy)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf_err <= 1'b0;
        end else if (|w_ovf) begin
            r_ovf_err <= 1'b1;
        end
    end

    assign ovf_err = r_ovf_err;

endmodule

// File: tb/tb_wb_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_wb_scoreboard
// Directed testbench for wb_scoreboard. Inputs change 1 ns after each rising
// edge. Outputs are compared 1 ns later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_wb_scoreboard;
    import mips_defs::*;

    logic              clk;
    logic              reset;
    logic              issue_valid;
    logic [RES_W-1:0]  issue_res;
    logic [REG_AW-1:0] issue_a3;
    logic [REG_AW-1:0] rs_addr;
    logic [REG_AW-1:0] rt_addr;
    logic              rs_used;
    logic              rt_used;
    logic              md_start;
    logic              md_is_div;
    logic              md_use;
    logic [RES_W-1:0]  Res_W;
    logic [REG_AW-1:0] A3_W;
    logic              stall;
    logic              md_busy;
    logic              ovf_err;

    int n_cmp = 0;
    int n_err = 0;

    wb_scoreboard #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_res   (issue_res),
        .issue_a3    (issue_a3),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_used     (rs_used),
        .rt_used     (rt_used),
        .md_start    (md_start),
        .md_is_div   (md_is_div),
        .md_use      (md_use),
        .Res_W       (Res_W),
        .A3_W        (A3_W),
        .stall       (stall),
        .md_busy     (md_busy),
        .ovf_err     (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_res = RES_NW; issue_a3 = '0;
        rs_addr = '0; rt_addr = '0; rs_used = 1'b0; rt_used = 1'b0;
        md_start = 1'b0; md_is_div = 1'b0; md_use = 1'b0;
        Res_W = RES_NW; A3_W = '0;
    endtask

    task automatic issue(input logic [RES_W-1:0] res, input logic [REG_AW-1:0] a3);
        issue_valid = 1'b1; issue_res = res; issue_a3 = a3;
    endtask

    task automatic retire(input logic [RES_W-1:0] res, input logic [REG_AW-1:0] a3);
        Res_W = res; A3_W = a3;
    endtask

    task automatic read_rs(input logic [REG_AW-1:0] a);
        rs_used = 1'b1; rs_addr = a;
    endtask

    initial begin
        // ---- reset and idle ----
        reset = 1'b0;
        idle();
        tick(); tick();
        check("rst_stall", stall, 1'b0);
        check("rst_busy",  md_busy, 1'b0);
        check("rst_ovf",   ovf_err, 1'b0);
        for (int i = 0; i < 32; i++) begin
            rs_used = 1'b1; rs_addr = REG_AW'(i);
            rt_used = 1'b1; rt_addr = REG_AW'(31 - i);
            #1 check($sformatf("rst_probe_r%0d", i), stall, 1'b0);
        end
        idle();
        md_use = 1'b1;
        #1 check("rst_md_use", stall, 1'b0);
        idle();
        reset = 1'b1;
        tick();

        // ---- load-use on r8 ----
        issue(RES_DM, 5'd8);
        #1 check("lu_issue_nostall", stall, 1'b0);
        tick(); idle();
        read_rs(5'd8);
        #1 check("lu_rs_stall", stall, 1'b1);
        rs_used = 1'b0; rt_used = 1'b1; rt_addr = 5'd8;
        #1 check("lu_rt_stall", stall, 1'b1);
        rt_used = 1'b0; read_rs(5'd8);
        retire(RES_DM, 5'd8);
        #1 check("lu_retire_cycle_still", stall, 1'b1);
        tick(); idle();
        read_rs(5'd8);
        #1 check("lu_after_retire", stall, 1'b0);
        check("lu_ovf", ovf_err, 1'b0);

        // ---- ALU writer never stalls; r0 never pending ----
        idle(); issue(RES_ALU, 5'd9);
        tick(); idle();
        rt_used = 1'b1; rt_addr = 5'd9;
        #1 check("alu_rt_nostall", stall, 1'b0);
        issue(RES_DM, 5'd0);
        tick(); idle();
        read_rs(5'd0);
        #1 check("r0_never_pending", stall, 1'b0);
        retire(RES_ALU, 5'd9);
        tick(); idle();
        retire(RES_DM, 5'd0);
        tick(); idle();
        check("r0_retire_ignored", ovf_err, 1'b0);
        // codes 5-7 behave as no-write on both sides
        issue(3'd5, 5'd12);
        tick(); idle();
        retire(3'd7, 5'd12);
        tick(); idle();
        check("res7_no_underflow", ovf_err, 1'b0);

        // ---- simultaneous issue and retire on r10 ----
        issue(RES_DM, 5'd10);
        tick(); idle();
        read_rs(5'd10);
        #1 check("sim_dm_stall", stall, 1'b1);
        // stalled issue to r11 must not count
        issue(RES_DM, 5'd11);
        tick(); idle();
        read_rs(5'd11);
        #1 check("stalled_issue_ignored", stall, 1'b0);
        idle();
        issue(RES_ALU, 5'd10); retire(RES_DM, 5'd10);
        tick(); idle();
        read_rs(5'd10);
        #1 check("sim_swap_to_alu", stall, 1'b0);
        idle();
        issue(RES_MD, 5'd10); retire(RES_ALU, 5'd10);
        tick(); idle();
        read_rs(5'd10);
        #1 check("sim_swap_to_md", stall, 1'b1);
        idle(); retire(RES_MD, 5'd10);
        tick(); idle();
        read_rs(5'd10);
        #1 check("sim_drained", stall, 1'b0);
        check("sim_ovf", ovf_err, 1'b0);

        // ---- div: busy for exactly 10 cycles ----
        idle();
        issue(RES_MD, 5'd0); md_start = 1'b1; md_is_div = 1'b1; md_use = 1'b1;
        #1 check("div_issue_nostall", stall, 1'b0);
        tick(); idle();
        md_use = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            #1;
            check($sformatf("div_busy_c%0d", k), md_busy, 1'b1);
            check($sformatf("div_stall_c%0d", k), stall, 1'b1);
            tick();
        end
        #1;
        check("div_busy_c11", md_busy, 1'b0);
        check("div_stall_c11", stall, 1'b0);

        // ---- mult: busy for exactly 5 cycles ----
        idle();
        issue(RES_MD, 5'd0); md_start = 1'b1; md_is_div = 1'b0;
        tick(); idle();
        for (int k = 1; k <= 5; k++) begin
            check($sformatf("mult_busy_c%0d", k), md_busy, 1'b1);
            tick();
        end
        check("mult_busy_c6", md_busy, 1'b0);

        // ---- underflow, sticky ----
        retire(RES_ALU, 5'd5);
        tick(); idle();
        check("uf_ovf_set", ovf_err, 1'b1);
        tick(); tick();
        check("uf_ovf_sticky", ovf_err, 1'b1);

        // ---- asynchronous reset mid-div ----
        issue(RES_MD, 5'd0); md_start = 1'b1; md_is_div = 1'b1;
        tick(); idle();
        tick(); tick();
        check("ar_busy_before", md_busy, 1'b1);
        reset = 1'b0;
        #1;
        check("ar_busy_cleared", md_busy, 1'b0);
        check("ar_ovf_cleared", ovf_err, 1'b0);
        tick();
        reset = 1'b1;
        tick();

        // ---- overflow: CNT_W=2 saturates at 3 ----
        for (int k = 1; k <= 3; k++) begin
            issue(RES_DM, 5'd13);
            tick(); idle();
        end
        check("of_not_yet", ovf_err, 1'b0);
        issue(RES_DM, 5'd13);
        tick(); idle();
        check("of_set", ovf_err, 1'b1);
        retire(RES_DM, 5'd13); tick();
        retire(RES_DM, 5'd13); tick();
        idle(); read_rs(5'd13);
        #1 check("of_one_left", stall, 1'b1);
        retire(RES_DM, 5'd13);
        tick(); idle();
        read_rs(5'd13);
        #1 check("of_drained", stall, 1'b0);
        check("of_sticky", ovf_err, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_scoreboard.md
Name: wb_scoreboard

Overview:
- Consumer end of the Res/A3 write-back tag stream. Tracks in-flight register writes from issue (D->E) to retirement (the W-stage Res_W/A3_W pair).
- Raises a conservative interlock when a D-stage instruction reads a register whose pending writer cannot be forwarded.
- Sequences a multi-cycle mult/div busy counter and stalls HI/LO users while it runs.
- Sits beside the D-stage decoder; its stall output freezes PC and the D register and bubbles E.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu.
- DIV_CYCLES, 10, busy cycles for div/divu.
- CNT_W, 2, width of each per-register pending counter.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- issue_valid  in  1  D-stage instruction advances into E this cycle
- issue_res  in  3  Res code of the issuing instruction
- issue_a3  in  5  destination register of the issuing instruction
- rs_addr  in  5  D-stage source rs
- rt_addr  in  5  D-stage source rt
- rs_used  in  1  D instruction reads rs
- rt_used  in  1  D instruction reads rt
- md_start  in  1  issuing instruction is mult/div (qualified by issue_valid)
- md_is_div  in  1  1 = div/divu, 0 = mult/multu
- md_use  in  1  D instruction is mfhi/mflo/mthi/mtlo/mult/div
- Res_W  in  3  Res code retiring in W
- A3_W  in  5  destination register retiring in W
- stall  out  1  freeze D, bubble E
- md_busy  out  1  mult/div unit running
- ovf_err  out  1  sticky: a pending counter overflowed or underflowed

Behaviour:
- Res codes: NW=0 (no write), ALU=1, DM=2, PC=3, MD=4; codes 5-7 are treated as NW.
- Reset (reset=0, asynchronous): all pending counters=0, all slow bits=0, md counter=0; md_busy=0, ovf_err=0, stall=0.
- Per register r in 1..31: pending counter cnt[r] (CNT_W bits) and slow bit slow[r]. Register 0 is never pending; writes to 0 are ignored on both the issue and retire sides.
- inc[r] = issue_valid & issue_res!=NW & issue_a3==r & !stall.
- dec[r] = Res_W!=NW & A3_W==r.
- Counter update on posedge clk:
  - inc and dec together: cnt unchanged.
  - inc only: cnt+1. At max it saturates and sets ovf_err.
  - dec only: cnt-1. At 0 it stays 0 and sets ovf_err.
- slow[r] on inc: set if issue_res is DM or MD, cleared if ALU or PC. On dec that brings cnt to 0: cleared. inc has priority over dec-to-zero.
- stall (combinational from state + D inputs) is the OR of:
  - rs_used & rs_addr!=0 & cnt[rs]!=0 & slow[rs]
  - rt_used & rt_addr!=0 & cnt[rt]!=0 & slow[rt]
  - md_use & md_busy
- The interlock is conservative: a slow writer blocks its readers until it retires. ALU/PC writers are assumed forwardable and never stall.
- md counter:
  - Loads MULT_CYCLES or DIV_CYCLES on issue_valid & md_start & !stall; otherwise decrements to 0.
  - md_busy = (counter != 0).
  - A new md_start while busy cannot occur, because md_use stalls it.
- Latency: the issue-side effect is visible the cycle after the issue edge. Retirement is visible the cycle after Res_W/A3_W are sampled.
- Reset asserted mid-operation clears everything immediately. No retire of pre-reset entries is expected afterwards.

Decomposition:
- Shared package (mips_defs): RES_NW/RES_ALU/RES_DM/RES_PC/RES_MD, the Res code width, and the register address width.
- One natural sub-module: md_busy_ctr, holding the loadable down-counter with the busy flag.
- Per-register counter and slow-bit logic is a generate loop in the top.

Test Plan:
- Reset then idle: reset=0 for 2 cycles -> stall=0, md_busy=0, ovf_err=0. All counters read 0 via stall probing.
- Load-use: issue DM to r8. Next cycle rs_used=1, rs_addr=8 -> stall=1. Retire Res_W=2, A3_W=8 -> stall=0 the following cycle.
- ALU hazard: issue ALU to r9, then read rt=9 -> stall=0 throughout. Issue ALU to r0 with rs_addr=0 -> never pending.
- Simultaneous issue and retire of r10 (count 1 -> 1): slow bit follows the new issue's Res; stall matches the new writer type.
- Div: md_start, md_is_div=1 -> md_busy=1 for exactly 10 cycles. md_use=1 during that window -> stall=1, and stall=0 on cycle 11.
- Underflow: retire Res_W=1, A3_W=5 with nothing pending -> ovf_err=1 and sticky until reset. Asynchronous reset mid-div -> md_busy=0 immediately.
